// File: rtl/seg_scan_driver.sv
// Time-multiplexed scan driver for a 4-digit common-anode 7-segment display.
// Optional build macro LEADING_ZERO_BLANK_EN keeps leading-zero digits dark.
module seg_scan_driver #(
    parameter int CNT_WIDTH    = 16,
    parameter int DIGIT_PERIOD = 50000,
    parameter int BLANK_CYCLES = 2000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] msg_in,
    input  logic        msg_load,
    output logic        msg_ack,
    output logic [3:0]  char,
    output logic [3:0]  an,
    output logic        frame_tick,
    output logic        dbg_state
);

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } state_t;

    localparam logic [CNT_WIDTH-1:0] LAST      = CNT_WIDTH'(DIGIT_PERIOD - 1);
    localparam logic [CNT_WIDTH-1:0] BLANK_END = CNT_WIDTH'(BLANK_CYCLES);

    state_t                 state, state_next;
    logic [CNT_WIDTH-1:0]   slot_cnt, cnt_next;
    logic [1:0]             idx, idx_next;
    logic [15:0]            disp_reg, disp_next;
    logic [15:0]            stage_reg, stage_next;
    logic                   pending, pending_next;
    logic [3:0]             char_next;
    logic [3:0]             lit;
    logic                   wrap;
    logic                   boundary;

    // Load/ack handshake: any cycle with msg_load=1 stages msg_in (latest wins)
    // and marks it pending; the pending message is committed to the display on
    // the frame-boundary edge, and msg_ack is high during that boundary cycle.
    always_comb begin
        wrap         = (slot_cnt == LAST);
        boundary     = wrap && (idx == 2'd3);
        cnt_next     = wrap ? '0 : slot_cnt + 1'b1;
        idx_next     = wrap ? idx + 2'd1 : idx;
        state_next   = (cnt_next < BLANK_END) ? BLANK : DRIVE;
        disp_next    = (boundary && pending) ? stage_reg : disp_reg;
        stage_next   = msg_load ? msg_in : stage_reg;
        pending_next = pending;
        if (msg_load) begin
            pending_next = 1'b1;
        end else if (boundary) begin
            pending_next = 1'b0;
        end
        // char follows the next slot's digit so the decoder settles during BLANK
        case (idx_next)
            2'd0:    char_next = disp_next[3:0];
            2'd1:    char_next = disp_next[7:4];
            2'd2:    char_next = disp_next[11:8];
            default: char_next = disp_next[15:12];
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= BLANK;
            slot_cnt  <= '0;
            idx       <= 2'd0;
            disp_reg  <= 16'h0000;
            stage_reg <= 16'h0000;
            pending   <= 1'b0;
            char      <= 4'h0;
        end else begin
            state     <= state_next;
            slot_cnt  <= cnt_next;
            idx       <= idx_next;
            disp_reg  <= disp_next;
            stage_reg <= stage_next;
            pending   <= pending_next;
            char      <= char_next;
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    // Digit k is lit only if some nibble at position k or above is nonzero
    always_comb begin
        lit[3] = (disp_reg[15:12] != 4'h0);
        lit[2] = lit[3] || (disp_reg[11:8] != 4'h0);
        lit[1] = lit[2] || (disp_reg[7:4] != 4'h0);
        lit[0] = 1'b1;
    end
`else
    assign lit = 4'b1111;
`endif

    always_comb begin
        an = 4'b1111;
        if (state == DRIVE) begin
            an[idx] = ~lit[idx];
        end
    end

    assign frame_tick = (slot_cnt == LAST) && (idx == 2'd3);
    assign msg_ack    = frame_tick && pending;
    assign dbg_state  = state;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver with a slot/frame-arithmetic reference model.
module tb_seg_scan_driver;

    localparam int CW = 4;
    localparam int DP = 8;
    localparam int BC = 2;
    localparam int FRAME = 4 * DP;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] msg_in = 16'h0000;
    logic        msg_load = 1'b0;
    logic        msg_ack;
    logic [3:0]  char;
    logic [3:0]  an;
    logic        frame_tick;
    logic        dbg_state;

    int checks = 0;
    int errors = 0;

    seg_scan_driver #(
        .CNT_WIDTH(CW),
        .DIGIT_PERIOD(DP),
        .BLANK_CYCLES(BC)
    ) dut (
        .clk(clk),
        .reset(reset),
        .msg_in(msg_in),
        .msg_load(msg_load),
        .msg_ack(msg_ack),
        .char(char),
        .an(an),
        .frame_tick(frame_tick),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Reference model: t counts clock edges since reset release; every other
    // quantity is derived from t with plain arithmetic.
    int          t;
    logic [15:0] disp_m, stage_m;
    logic        pend_m;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            t       <= 0;
            disp_m  <= 16'h0000;
            stage_m <= 16'h0000;
            pend_m  <= 1'b0;
        end else begin
            t <= t + 1;
            if ((t % FRAME) == FRAME - 1 && pend_m) disp_m <= stage_m;
            if (msg_load) begin
                stage_m <= msg_in;
                pend_m  <= 1'b1;
            end else if ((t % FRAME) == FRAME - 1) begin
                pend_m <= 1'b0;
            end
        end
    end

    function automatic logic [10:0] exp_out();
        int   slot, digit;
        logic drive, lit, tick;
        logic [3:0] e_an, e_char;
        slot   = t % DP;
        digit  = (t / DP) % 4;
        drive  = (slot >= BC);
        e_char = 4'((disp_m >> (4 * digit)) & 16'h000F);
`ifdef LEADING_ZERO_BLANK_EN
        lit = (digit == 0) || ((disp_m >> (4 * digit)) != 16'h0000);
`else
        lit = 1'b1;
`endif
        e_an = (drive && lit) ? ~(4'b0001 << digit) : 4'b1111;
        tick = ((t % FRAME) == FRAME - 1);
        return {e_an, e_char, tick, tick && pend_m, drive};
    endfunction

    wire [10:0] obs = {an, char, frame_tick, msg_ack, dbg_state};

    task automatic sync_frame();
        msg_load = 1'b0;
        for (int g = 0; g < FRAME + 4 && (t % FRAME) != 0; g++) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({an, char, frame_tick, msg_ack, dbg_state} !== 11'b1111_0000_0_0_0) begin
            errors++;
            $display("FAIL reset_values got %b exp %b", {an, char, frame_tick, msg_ack, dbg_state}, 11'b1111_0000_0_0_0);
        end
        reset = 1'b1;
    endtask

    task automatic test_idle();
        int acks = 0, ticks = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_out()) begin
                errors++;
                $display("FAIL idle t=%0d got %b exp %b", t, obs, exp_out());
            end
            if (msg_ack) acks++;
            if (frame_tick) ticks++;
        end
        checks++;
        if (acks !== 0 || ticks !== 2) begin
            errors++;
            $display("FAIL idle_counts acks=%0d ticks=%0d exp acks=0 ticks=2", acks, ticks);
        end
    endtask

    task automatic test_single_load();
        int acks = 0;
        sync_frame();
        for (int i = 0; i < 2 * FRAME + 8; i++) begin
            checks++;
            if (obs !== exp_out()) begin
                errors++;
                $display("FAIL single_load t=%0d got %b exp %b", t, obs, exp_out());
            end
            if (msg_ack) acks++;
            if (i == 20 && char !== 4'h0) begin
                errors++;
                $display("FAIL single_load_early char got %h exp 0", char);
            end
            if (i == 35 && {an, char} !== {4'b1110, 4'h5}) begin
                errors++;
                $display("FAIL single_load_d0 got %b exp %b", {an, char}, {4'b1110, 4'h5});
            end
            if (i == 59 && {an, char} !== {4'b0111, 4'hA}) begin
                errors++;
                $display("FAIL single_load_d3 got %b exp %b", {an, char}, {4'b0111, 4'hA});
            end
            msg_load = (i == 10);
            msg_in   = 16'hA3C5;
            @(negedge clk);
        end
        checks += 3;
        if (acks !== 1) begin
            errors++;
            $display("FAIL single_load_acks got %0d exp 1", acks);
        end
    endtask

    task automatic test_double_load();
        int acks = 0;
        sync_frame();
        for (int i = 0; i < FRAME + 8; i++) begin
            checks++;
            if (obs !== exp_out()) begin
                errors++;
                $display("FAIL double_load t=%0d got %b exp %b", t, obs, exp_out());
            end
            if (msg_ack) acks++;
            msg_load = (i == 5) || (i == 12);
            msg_in   = (i == 5) ? 16'h1111 : 16'h2222;
            @(negedge clk);
        end
        checks += 2;
        if (acks !== 1) begin
            errors++;
            $display("FAIL double_load_acks got %0d exp 1", acks);
        end
        if (char !== 4'h2) begin
            errors++;
            $display("FAIL double_load_char got %h exp 2", char);
        end
    endtask

    task automatic test_load_on_boundary();
        int acks = 0;
        sync_frame();
        for (int i = 0; i < 2 * FRAME + 8; i++) begin
            checks++;
            if (obs !== exp_out()) begin
                errors++;
                $display("FAIL boundary_load t=%0d got %b exp %b", t, obs, exp_out());
            end
            if (msg_ack) acks++;
            if (i == 34 && char !== 4'h4) begin
                errors++;
                $display("FAIL boundary_first char got %h exp 4", char);
            end
            if (i == 66 && char !== 4'hF) begin
                errors++;
                $display("FAIL boundary_second char got %h exp f", char);
            end
            msg_load = (i == 3) || (i == FRAME - 1);
            msg_in   = (i == 3) ? 16'h1234 : 16'hBEEF;
            @(negedge clk);
        end
        checks += 2;
        if (acks !== 2) begin
            errors++;
            $display("FAIL boundary_acks got %0d exp 2", acks);
        end
    endtask

    task automatic test_async_reset();
        int acks = 0;
        sync_frame();
        for (int i = 0; i < 20; i++) begin
            msg_load = (i == 0);
            msg_in   = 16'h5A5A;
            @(negedge clk);
        end
        checks++;
        if (an !== 4'b1011) begin
            errors++;
            $display("FAIL async_pre an got %b exp 1011", an);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({an, char, frame_tick, msg_ack} !== 10'b1111_0000_0_0) begin
            errors++;
            $display("FAIL async_reset got %b exp %b", {an, char, frame_tick, msg_ack}, 10'b1111_0000_0_0);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < FRAME + 8; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_out()) begin
                errors++;
                $display("FAIL async_after t=%0d got %b exp %b", t, obs, exp_out());
            end
            if (msg_ack) acks++;
        end
        checks += 2;
        if (acks !== 0) begin
            errors++;
            $display("FAIL async_acks got %0d exp 0", acks);
        end
    endtask

    task automatic test_lzb();
        logic [3:0] low_mask = 4'b0000;
        logic [3:0] exp_mask;
`ifdef LEADING_ZERO_BLANK_EN
        exp_mask = 4'b0011;
`else
        exp_mask = 4'b1111;
`endif
        sync_frame();
        for (int i = 0; i < 2 * FRAME; i++) begin
            checks++;
            if (obs !== exp_out()) begin
                errors++;
                $display("FAIL lzb t=%0d got %b exp %b", t, obs, exp_out());
            end
            if (i >= FRAME) low_mask = low_mask | ~an;
            msg_load = (i == 0);
            msg_in   = 16'h0040;
            @(negedge clk);
        end
        checks++;
        if (low_mask !== exp_mask) begin
            errors++;
            $display("FAIL lzb_mask got %b exp %b", low_mask, exp_mask);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            checks++;
            if (obs !== exp_out()) begin
                errors++;
                $display("FAIL random t=%0d got %b exp %b", t, obs, exp_out());
            end
            msg_load = ($urandom_range(0, 9) == 0);
            msg_in   = 16'($urandom);
            @(negedge clk);
        end
        msg_load = 1'b0;
    endtask

    initial begin
        test_reset();
        test_idle();
        test_single_load();
        test_double_load();
        test_load_on_boundary();
        test_async_reset();
        test_lzb();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
